// File: rtl/sr_latch_driver_if.sv
// Command and latch-drive bundle between a command source (master) and sr_latch_driver (slave).
// cmd_valid/cmd_ready: a command transfers on a rising edge where both are high; cmd_op is only meaningful then.
interface sr_latch_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       S;
    logic       R;
    logic       En;
    logic       Q_fb;
    logic       notQ_fb;
    logic       q_exp;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;

    modport master (
        output cmd_valid,
        output cmd_op,
        output Q_fb,
        output notQ_fb,
        input  cmd_ready,
        input  S,
        input  R,
        input  En,
        input  q_exp,
        input  done,
        input  err,
        input  dbg_state
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  Q_fb,
        input  notQ_fb,
        output cmd_ready,
        output S,
        output R,
        output En,
        output q_exp,
        output done,
        output err,
        output dbg_state
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Sequences S/R/En for a gated SR latch: setup, enable pulse, hold, settle, check.
// Optional macro SR_DRV_CHECK_EN enables the Q/notQ feedback comparison; otherwise err is tied low.
module sr_latch_driver #(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input logic              Clk,
    input logic              Rst,
    sr_latch_driver_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_PULSE  = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_drv_q, s_drv_d;
    logic             r_drv_q, r_drv_d;
    logic             t_q, t_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             en_q, en_d;
    logic             q_exp_q, q_exp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic accept;
    logic eff_set;
    logic eff_reset;
    logic tgt;
    logic drive_sr;

    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

    // Toggle resolves against the value the latch should hold now, so S and R stay exclusive.
    always_comb begin
        eff_set   = 1'b0;
        eff_reset = 1'b0;
        tgt       = q_exp_q;
        case (bus.cmd_op)
            2'b01: begin
                eff_set = 1'b1;
                tgt     = 1'b1;
            end
            2'b10: begin
                eff_reset = 1'b1;
                tgt       = 1'b0;
            end
            2'b11: begin
                eff_set   = ~q_exp_q;
                eff_reset = q_exp_q;
                tgt       = ~q_exp_q;
            end
            default: begin
                eff_set   = 1'b0;
                eff_reset = 1'b0;
                tgt       = q_exp_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = PULSE_LOAD;
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (SETTLE_CYCLES > 0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_drv_d = s_drv_q;
        r_drv_d = r_drv_q;
        t_d     = t_q;
        if (accept) begin
            s_drv_d = eff_set;
            r_drv_d = eff_reset;
            t_d     = tgt;
        end
    end

    // Drive outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        drive_sr = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        s_d      = drive_sr & s_drv_d;
        r_d      = drive_sr & r_drv_d;
        en_d     = (state_d == ST_PULSE);
        done_d   = (state_d == ST_CHECK);
        q_exp_d  = q_exp_q;
        if ((state_q == ST_PULSE) && (state_d == ST_HOLD)) begin
            q_exp_d = t_q;
        end
    end

`ifdef SR_DRV_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (state_q == ST_CHECK) begin
            err_d = (bus.Q_fb != q_exp_q) | (bus.notQ_fb != ~q_exp_q);
        end
    end
`else
    logic unused_fb;
    assign unused_fb = bus.Q_fb ^ bus.notQ_fb ^ err_q;
    assign err_d     = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_drv_q <= 1'b0;
            r_drv_q <= 1'b0;
            t_q     <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            en_q    <= 1'b0;
            q_exp_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_drv_q <= s_drv_d;
            r_drv_q <= r_drv_d;
            t_q     <= t_d;
            s_q     <= s_d;
            r_q     <= r_d;
            en_q    <= en_d;
            q_exp_q <= q_exp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.S         = s_q;
    assign bus.R         = r_q;
    assign bus.En        = en_q;
    assign bus.q_exp     = q_exp_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: table of commands against a behavioural gated SR latch,
// plus hand-written reset-abort and busy-ignore sequences.
module tb_sr_latch_driver;

    localparam int P   = 2;
    localparam int ST  = 1;
    localparam int LAT = 3 + P + ST;

    typedef struct {
        logic [1:0] op;
        logic       force_bad;
        logic       spur;
        logic       exp_s;
        logic       exp_r;
        logic       exp_t;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic force_bad;
    logic latch_q = 1'b0;
    logic model_q;
    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    vec_t vecs[10];

    sr_latch_driver_if bus();

    sr_latch_driver #(
        .PULSE_CYCLES (P),
        .SETTLE_CYCLES(ST),
        .CNT_W        (4)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    // Clock and the latch that the driver feeds.
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.En === 1'b1) begin
            if (bus.S && !bus.R) latch_q <= 1'b1;
            else if (bus.R && !bus.S) latch_q <= 1'b0;
        end
    end

    assign bus.Q_fb    = force_bad ? 1'b0 : latch_q;
    assign bus.notQ_fb = force_bad ? 1'b1 : ~latch_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic err_expect(input logic e);
`ifdef SR_DRV_CHECK_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    // Issue one command and check every cycle of its sequence plus two idle cycles.
    task automatic run_cmd(input vec_t v);
        int   dones;
        logic q_before;
        logic e_s, e_r, e_en, e_done, e_ready, e_q, popped;
        dones    = 0;
        q_before = model_q;
        @(negedge clk);
        check("ready_before_cmd", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        force_bad     = v.force_bad;
        exp_q.push_back(v.exp_t);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            e_s     = (c >= 1 && c <= 2 + P) ? v.exp_s : 1'b0;
            e_r     = (c >= 1 && c <= 2 + P) ? v.exp_r : 1'b0;
            e_en    = (c >= 2 && c <= 1 + P);
            e_done  = (c == LAT);
            e_ready = (c >= LAT + 1);
            e_q     = (c >= 2 + P) ? v.exp_t : q_before;
            check("S", bus.S, e_s);
            check("R", bus.R, e_r);
            check("En", bus.En, e_en);
            check("S_and_R", bus.S & bus.R, 1'b0);
            check("done", bus.done, e_done);
            check("cmd_ready", bus.cmd_ready, e_ready);
            check("q_exp", bus.q_exp, e_q);
            if (bus.done === 1'b1) begin
                dones++;
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    popped = exp_q.pop_front();
                    check("q_exp_at_done", bus.q_exp, popped);
                end
            end
            if (c == LAT + 1) check("err", bus.err, err_expect(v.exp_err));
            if (v.spur && c == 2) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'b10;
            end
            if (v.spur && c == 2 + P) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op    = 2'b00;
            end
        end
        check("done_count", dones, 1);
        model_q   = v.exp_t;
        force_bad = 1'b0;
    endtask

    // Reset asserted while En is high must abort without a done pulse.
    task automatic reset_abort();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("abort_en_before", bus.En, 1'b1);
        check("abort_r_before", bus.R, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_En", bus.En, 1'b0);
        check("abort_S", bus.S, 1'b0);
        check("abort_R", bus.R, 1'b0);
        check("abort_q_exp", bus.q_exp, 1'b0);
        check("abort_ready", bus.cmd_ready, 1'b1);
        check("abort_err", bus.err, 1'b0);
        for (int c = 0; c < LAT + 2; c++) begin
            check("abort_no_done", bus.done, 1'b0);
            check("abort_idle_en", bus.En, 1'b0);
            @(negedge clk);
        end
        model_q = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        force_bad     = 1'b0;
        model_q       = 1'b0;

        //          op     bad   spur  S     R     t     err
        vecs[0] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_S", bus.S, 1'b0);
        check("rst_R", bus.R, 1'b0);
        check("rst_En", bus.En, 1'b0);
        check("rst_q_exp", bus.q_exp, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_ready", bus.cmd_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i]);
        end

        reset_abort();
        run_cmd('{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Clocked command sequencer that sits directly upstream of the gated SR latch and generates its S, R and En inputs.
- Turns single-cycle set/reset/toggle/hold commands into a safe sequence: data setup, enable pulse, data hold, settle.
- Never drives S=R=1.
- Samples the latch's Q/notQ feedback and flags a mismatch against the value it expects the latch to hold.

Parameters:
PULSE_CYCLES, 2, number of cycles En is held high (legal range 1..2^CNT_W-1).
SETTLE_CYCLES, 1, idle cycles after hold before feedback check (0 = SETTLE state skipped).
CNT_W, 4, width of the internal phase counter.

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_op  input  2  00 hold, 01 set, 10 reset, 11 toggle.
cmd_ready  output  1  high only in IDLE; command accepted on an edge where cmd_valid & cmd_ready.
S  output  1  registered set drive to latch.
R  output  1  registered reset drive to latch.
En  output  1  registered enable drive to latch.
Q_fb  input  1  latch Q feedback.
notQ_fb  input  1  latch notQ feedback.
q_exp  output  1  value the latch is expected to hold.
done  output  1  one-cycle pulse in CHECK.
err  output  1  feedback mismatch flag.

Behaviour:
- Reset (Rst=1 at an edge):
  - state=IDLE; S=R=En=0; q_exp=0; done=0; err=0; counter=0.
  - cmd_ready=1 from the cycle after reset.
  - Reset mid-sequence aborts at the next edge with the same values; the latch itself is not reset.
- States: IDLE -> SETUP -> PULSE -> HOLD -> SETTLE -> CHECK -> IDLE.
- Accept at edge k: latch the target value t.
  - 01: t=1.
  - 10: t=0.
  - 11: t=~q_exp.
  - 00: t=q_exp.
- Drive values derived from t and the op:
  - S=1 only for an effective set (01, or 11 with q_exp=0).
  - R=1 only for an effective reset (10, or 11 with q_exp=1).
  - Hold (00) drives S=R=0.
- SETUP (1 cycle, from k+1): S/R driven, En=0.
- PULSE (PULSE_CYCLES cycles): S/R unchanged, En=1.
  - q_exp<=t on the edge leaving PULSE.
- HOLD (1 cycle): En=0, S/R unchanged.
- SETTLE (SETTLE_CYCLES cycles): S=R=En=0. Skipped when SETTLE_CYCLES=0.
- CHECK (1 cycle): S=R=En=0, done=1.
  - err is registered at the end of CHECK: err <= (Q_fb!=q_exp) | (notQ_fb!=~q_exp).
  - err holds until the next CHECK or reset.
- Latency: accept to done-high = 3+PULSE_CYCLES+SETTLE_CYCLES cycles (defaults: done high in cycle k+6). cmd_ready returns the cycle after CHECK.
- cmd_valid while busy: ignored; no queuing; cmd_op sampled only at acceptance.
- Back-to-back: a command held valid is accepted on the first IDLE cycle, giving a minimum period of 4+PULSE_CYCLES+SETTLE_CYCLES.
- Invariants:
  - S&R is never 1.
  - S/R never change while En=1.
  - En is never high outside PULSE.
- Counter counts down from PULSE_CYCLES-1 / SETTLE_CYCLES-1; wraps never occur for legal parameters.

Optional Feature:
SR_DRV_CHECK_EN
- Defined: Q_fb/notQ_fb are compared in CHECK and err is updated as above.
- Undefined: feedback inputs are ignored and err is tied 0. The CHECK state, done timing and latency are unchanged.

Test Plan:
- Rst=1 for 2 edges, then release -> S=R=En=0, q_exp=0, err=0, cmd_ready=1.
- After reset, set (cmd_op=01) at edge 0, feedback model = real gated SR latch -> S=1 cycles 1-4, En=1 cycles 2-3, q_exp=1 from cycle 4, done=1 cycle 6, err=0, cmd_ready=1 cycle 7.
- Toggle (11) with q_exp=1 -> R=1 (S=0), q_exp=0 after PULSE. A second toggle gives S=1 and q_exp=1. S&R=0 every cycle.
- cmd_valid pulsed during PULSE with op=10 -> ignored; q_exp and S/R unchanged; only one done pulse.
- Feedback forced Q_fb=0, notQ_fb=1 during a set (macro defined) -> err=1 after CHECK, cleared by the next correct command. Same stimulus with the macro undefined -> err=0.
- Rst asserted during PULSE (En=1) -> next edge En=S=R=0, state IDLE, q_exp=0, no done pulse.
